spi_xfer_ctrl: RTL and testbench
================================

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter CS_SETUP, default 1 (range 1..15): cycles `cs_n` is low before the first `shift_on`.
REQ-002 SHALL have parameter CS_HOLD, default 1 (range 1..15): cycles `cs_n` is forced high after a non-held transfer.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the system clock, the same clock as the downstream shifter.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports cmd_valid (in, 1) and cmd_ready (out, 1): the command handshake.
REQ-007 SHALL have ports cmd_data (in, 32) and cmd_wlen (in, 5): TX word and bit count minus one.
REQ-008 SHALL have ports cmd_mode (in, 2), cmd_csnum (in, 2) and cmd_hold (in, 1).
- cmd_mode: 0 = full-duplex, 1 = sread, 2 = dread, 3 = treated as 0.
- cmd_hold: keep CS asserted after the transfer.
REQ-009 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1) and rsp_data (out, 32): the response handshake.
REQ-010 SHALL have shifter-side ports, all outputs: shift_on, shift_out_load, idle, cs_n, sread, dread, write_en (1 each); shift_out_data (32); wlen_ot (5); csnum (2).
REQ-011 SHALL have port shift_in_data, input, 32 bits: the shifter capture register.

Function
REQ-012 SHALL accept a command on cmd_valid && cmd_ready; cmd_ready SHALL be 1 only in IDLE.
REQ-013 SHALL register the command fields on acceptance, which drive the shifter outputs:
- shift_out_data, wlen_ot and csnum from the command;
- write_en = (mode==0 || mode==3), sread = (mode==1), dread = (mode==2).
REQ-014 SHALL implement FSM states IDLE, LOAD, SETUP, SHIFT, TAIL, DONE, CSOFF.
REQ-015 SHALL sequence accept cycle T → LOAD at T+1, with shift_out_load=1 for exactly one cycle, cs_n=0 and idle=0.
REQ-016 SHALL go from LOAD to SETUP for CS_SETUP cycles with shift_on=0. When CS is already held on the same csnum, SETUP SHALL be skipped (LOAD→SHIFT).
REQ-017 SHALL hold shift_on=1 in SHIFT for N consecutive cycles:
- N = wlen+1 in modes 0, 1, 3;
- N = (wlen+2)>>1 in mode 2.
REQ-018 SHALL spend exactly 2 cycles in TAIL with shift_on=0 and cs_n=0, covering the shifter's two-cycle capture lag.
REQ-019 SHALL capture shift_in_data into the response slot in DONE, once the slot is free. DONE SHALL wait while the slot is full.
REQ-020 SHALL exit DONE as follows:
- hold=0 → CSOFF: cs_n=1 for CS_HOLD cycles, then IDLE;
- hold=1 → IDLE with cs_n kept at 0.
REQ-021 SHALL, when a command arrives while CS is held and its csnum differs, go through CSOFF (CS_HOLD cycles) before LOAD.
REQ-022 SHALL drive idle=1 only in IDLE with cs_n=1.
REQ-023 SHALL keep rsp_valid high with rsp_data stable until rsp_ready; pop occurs on rsp_valid && rsp_ready.
REQ-024 SHALL treat a pop and a capture in the same cycle as legal; the slot stays occupied with the new data.
REQ-025 SHALL produce a minimum command-to-response latency of 1+1+CS_SETUP+N+2+1 cycles.

Reset
REQ-026 SHALL, when rst is sampled high, on the next edge and from any state including mid-SHIFT:
- set state=IDLE, cs_n=1, idle=1, shift_on=0, shift_out_load=0, cmd_ready=0 during reset;
- set rsp_valid=0 and clear the response storage;
- clear all registered command fields to 0.
REQ-027 SHALL assert cmd_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-028 SHALL compile in SPI_XFER_CTRL_RSP_SKID_EN as follows:
- Defined: response storage is a 2-entry FIFO, and DONE stalls only when both entries are full.
- Undefined: a single response register, and DONE stalls while rsp_valid && !rsp_ready.
- Ordering and rsp_data values SHALL be identical in both builds.

Structure
REQ-029 SHALL take from shared package spi_xfer_pkg:
- the state enum;
- mode codes MODE_FDX, MODE_SREAD, MODE_DREAD;
- default CS_SETUP/CS_HOLD constants.
REQ-030 SHALL place response storage in one sub-module spi_xfer_rsp_buf, with depth 1 or 2 set by the macro.

Verification
REQ-031 Bench SHALL cover: mode 0, wlen=7, data=0xA5, CS_SETUP=1 → one shift_out_load pulse, shift_on high for 8 cycles, rsp_valid at T+13, cs_n high for 1 cycle, then idle=1.
REQ-032 Bench SHALL cover: mode 2, wlen=7 → shift_on high for exactly 4 cycles; dread=1, write_en=0 throughout.
REQ-033 Bench SHALL cover: two commands with hold=1, same csnum=2 → cs_n stays 0 between them, no SETUP on the second, idle=0 in between.
REQ-034 Bench SHALL cover: hold=1 on csnum=0, then a command on csnum=1 → cs_n=1 for CS_HOLD cycles before the second LOAD.
REQ-035 Bench SHALL cover: rsp_ready=0 for 20 cycles across three commands →
- without the macro: FSM stalls in DONE after transfer 2;
- with the macro: FSM stalls after transfer 3;
- no data loss and in-order responses in both builds.
REQ-036 Bench SHALL cover: rst pulsed for 1 cycle in the 3rd SHIFT cycle → next cycle cs_n=1, shift_on=0, rsp_valid=0, idle=1.

Source files
------------

// File: rtl/spi_xfer_pkg.sv
// Shared types and constants for the SPI transfer controller: FSM states, mode codes, default CS timing.
package spi_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        SHIFT,
        TAIL,
        DONE,
        CSOFF
    } xfer_state_e;

    localparam logic [1:0] MODE_FDX   = 2'd0;
    localparam logic [1:0] MODE_SREAD = 2'd1;
    localparam logic [1:0] MODE_DREAD = 2'd2;

    localparam int CS_SETUP_DEF = 1;
    localparam int CS_HOLD_DEF  = 1;

    // Dual read moves two bits per shift cycle, so it needs half the cycles (rounded up).
    function automatic logic [4:0] shift_cycles_m1(input logic [1:0] mode, input logic [4:0] wlen);
        logic [5:0] n;
        n = (mode == MODE_DREAD) ? ((6'(wlen) + 6'd2) >> 1) : (6'(wlen) + 6'd1);
        return 5'(n - 6'd1);
    endfunction

endpackage

// File: rtl/spi_xfer_rsp_buf.sv
// Response storage for the SPI transfer controller: a single register (DEPTH=1) or a 2-entry FIFO (DEPTH=2).
module spi_xfer_rsp_buf
#(
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_data,
    output logic        full,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data
);

    generate
        if (DEPTH == 1) begin : g_reg
            logic        vld;
            logic [31:0] dat;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld <= 1'b0;
                    dat <= '0;
                end else if (push) begin
                    vld <= 1'b1;
                    dat <= push_data;
                end else if (vld && rsp_ready) begin
                    vld <= 1'b0;
                end
            end

            // A pop in the same cycle frees the slot for a new capture.
            assign full      = vld && !rsp_ready;
            assign rsp_valid = vld;
            assign rsp_data  = dat;
        end else begin : g_fifo
            logic [1:0]  cnt;
            logic [31:0] e0, e1;
            logic        pop;

            assign pop = (cnt != 2'd0) && rsp_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt <= '0;
                    e0  <= '0;
                    e1  <= '0;
                end else begin
                    case ({push, pop})
                        2'b10: begin
                            if (cnt == 2'd0) e0 <= push_data;
                            else             e1 <= push_data;
                            cnt <= cnt + 2'd1;
                        end
                        2'b01: begin
                            e0  <= e1;
                            cnt <= cnt - 2'd1;
                        end
                        2'b11: begin
                            if (cnt == 2'd1) begin
                                e0 <= push_data;
                            end else begin
                                e0 <= e1;
                                e1 <= push_data;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            assign full      = (cnt == 2'd2);
            assign rsp_valid = (cnt != 2'd0);
            assign rsp_data  = e0;
        end
    endgenerate

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer controller: accepts a command, sequences CS setup / shift / capture / CS release for the shifter.
// Define SPI_XFER_CTRL_RSP_SKID_EN to use a 2-entry response FIFO instead of a single response register.
module spi_xfer_ctrl
    import spi_xfer_pkg::*;
#(
    parameter int CS_SETUP = CS_SETUP_DEF,
    parameter int CS_HOLD  = CS_HOLD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    input  logic [4:0]  cmd_wlen,
    input  logic [1:0]  cmd_mode,
    input  logic [1:0]  cmd_csnum,
    input  logic        cmd_hold,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        shift_on,
    output logic        shift_out_load,
    output logic        idle,
    output logic        cs_n,
    output logic        sread,
    output logic        dread,
    output logic        write_en,
    output logic [31:0] shift_out_data,
    output logic [4:0]  wlen_ot,
    output logic [1:0]  csnum,
    input  logic [31:0] shift_in_data
);

`ifdef SPI_XFER_CTRL_RSP_SKID_EN
    localparam int RSP_DEPTH = 2;
`else
    localparam int RSP_DEPTH = 1;
`endif

    xfer_state_e state, state_nx;
    logic [4:0]  cnt, cnt_ld, shift_m1;
    logic        cs_held, pend_load, skip_setup, hold_r, rsp_got;
    logic        accept, push, rsp_full;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = (cs_held && cmd_csnum != csnum) ? CSOFF : LOAD;
            LOAD:  state_nx = skip_setup ? SHIFT : SETUP;
            SETUP: if (cnt == '0) state_nx = SHIFT;
            SHIFT: if (cnt == '0) state_nx = TAIL;
            TAIL:  if (cnt == '0) state_nx = DONE;
            DONE:  if (rsp_got || !rsp_full) state_nx = hold_r ? IDLE : CSOFF;
            CSOFF: if (cnt == '0) state_nx = pend_load ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready      = 1'b0;
        shift_out_load = 1'b0;
        shift_on       = 1'b0;
        cs_n           = 1'b0;
        idle           = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                cs_n      = !cs_held;
                idle      = !cs_held;
            end
            LOAD:  shift_out_load = 1'b1;
            SHIFT: shift_on       = 1'b1;
            CSOFF: cs_n           = 1'b1;
            default: ;
        endcase
    end

    // Capture on the last TAIL edge so the response is visible in DONE; a full slot defers it into DONE.
    assign push = !rsp_full && ((state == TAIL && cnt == '0) || (state == DONE && !rsp_got));

    always_comb begin
        cnt_ld = '0;
        case (state_nx)
            SETUP: cnt_ld = 5'(CS_SETUP - 1);
            SHIFT: cnt_ld = shift_m1;
            TAIL:  cnt_ld = 5'd1;
            CSOFF: cnt_ld = 5'(CS_HOLD - 1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            cs_held        <= 1'b0;
            pend_load      <= 1'b0;
            skip_setup     <= 1'b0;
            hold_r         <= 1'b0;
            rsp_got        <= 1'b0;
            shift_m1       <= '0;
            shift_out_data <= '0;
            wlen_ot        <= '0;
            csnum          <= '0;
            write_en       <= 1'b0;
            sread          <= 1'b0;
            dread          <= 1'b0;
        end else begin
            if (state_nx != state) cnt <= cnt_ld;
            else if (cnt != '0)    cnt <= cnt - 5'd1;
            rsp_got <= push && (state == TAIL);
            if (accept) begin
                shift_out_data <= cmd_data;
                wlen_ot        <= cmd_wlen;
                csnum          <= cmd_csnum;
                hold_r         <= cmd_hold;
                write_en       <= (cmd_mode == MODE_FDX) || (cmd_mode == 2'd3);
                sread          <= (cmd_mode == MODE_SREAD);
                dread          <= (cmd_mode == MODE_DREAD);
                shift_m1       <= shift_cycles_m1(cmd_mode, cmd_wlen);
                skip_setup     <= cs_held && (cmd_csnum == csnum);
                pend_load      <= cs_held && (cmd_csnum != csnum);
            end else if (state == LOAD) begin
                pend_load <= 1'b0;
            end
            if (state == DONE && state_nx == IDLE) cs_held <= 1'b1;
            else if (state_nx == CSOFF)            cs_held <= 1'b0;
        end
    end

    spi_xfer_rsp_buf #(.DEPTH(RSP_DEPTH)) u_rsp_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shift_in_data),
        .full      (rsp_full),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed self-checking bench for spi_xfer_ctrl; expectations follow the SPI_XFER_CTRL_RSP_SKID_EN build setting.
module tb_spi_xfer_ctrl;

`ifdef SPI_XFER_CTRL_RSP_SKID_EN
    localparam int EXP_ACC = 3;
`else
    localparam int EXP_ACC = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_hold;
    logic [31:0] cmd_data, rsp_data, shift_out_data, shift_in_data;
    logic [4:0]  cmd_wlen, wlen_ot;
    logic [1:0]  cmd_mode, cmd_csnum, csnum;
    logic        rsp_valid, rsp_ready;
    logic        shift_on, shift_out_load, idle, cs_n, sread, dread, write_en;

    int checks = 0;
    int errors = 0;

    logic        tr_load [1:32];
    logic        tr_on   [1:32];
    logic        tr_cs   [1:32];
    logic        tr_rv   [1:32];
    logic        tr_idle [1:32];
    logic        tr_wen  [1:32];
    logic        tr_dr   [1:32];
    logic [31:0] tr_rd   [1:32];

    always #5 clk = ~clk;

    spi_xfer_ctrl #(.CS_SETUP(1), .CS_HOLD(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_wlen(cmd_wlen),
        .cmd_mode(cmd_mode), .cmd_csnum(cmd_csnum), .cmd_hold(cmd_hold),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .shift_on(shift_on), .shift_out_load(shift_out_load), .idle(idle), .cs_n(cs_n),
        .sread(sread), .dread(dread), .write_en(write_en),
        .shift_out_data(shift_out_data), .wlen_ot(wlen_ot), .csnum(csnum),
        .shift_in_data(shift_in_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and returns in the cycle after the handshake (the LOAD cycle, or CSOFF on a CS switch).
    task automatic send(input logic [31:0] d, input logic [4:0] wl, input logic [1:0] md,
                        input logic [1:0] cs, input logic h);
        int n;
        cmd_data = d; cmd_wlen = wl; cmd_mode = md; cmd_csnum = cs; cmd_hold = h;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin step(); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL send_accept: cmd_ready=%b, expected 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic trace(input int len);
        for (int k = 1; k <= len; k++) begin
            tr_load[k] = shift_out_load; tr_on[k] = shift_on; tr_cs[k] = cs_n;
            tr_rv[k] = rsp_valid; tr_idle[k] = idle; tr_wen[k] = write_en;
            tr_dr[k] = dread; tr_rd[k] = rsp_data;
            step();
        end
    endtask

    function automatic int count_on(input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) if (tr_on[k]) c++;
        return c;
    endfunction

    function automatic int first_on(input int len);
        for (int k = 1; k <= len; k++) if (tr_on[k]) return k;
        return 0;
    endfunction

    function automatic int first_rv(input int len);
        for (int k = 1; k <= len; k++) if (tr_rv[k]) return k;
        return 0;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({cmd_ready, cs_n, idle, shift_on, shift_out_load, rsp_valid} !== 6'b011000) begin
            errors++;
            $display("FAIL reset_outputs: rdy/cs_n/idle/on/load/rv=%b, expected 011000",
                     {cmd_ready, cs_n, idle, shift_on, shift_out_load, rsp_valid});
        end
        checks++;
        if ({shift_out_data, wlen_ot, csnum, write_en} !== 40'd0) begin
            errors++; $display("FAIL reset_fields: data=%h wlen=%0d csnum=%0d wen=%b, expected 0",
                               shift_out_data, wlen_ot, csnum, write_en);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: cmd_ready=%b, expected 1", cmd_ready);
        end
    endtask

    task automatic test_fdx();
        int nload;
        shift_in_data = 32'h0000_005A;
        send(32'h0000_00A5, 5'd7, 2'd0, 2'd0, 1'b0);
        trace(16);
        nload = 0;
        for (int k = 1; k <= 16; k++) if (tr_load[k]) nload++;
        checks++;
        if (nload != 1 || tr_load[1] !== 1'b1) begin
            errors++; $display("FAIL fdx_load_pulse: count=%0d at_load=%b, expected 1 and 1", nload, tr_load[1]);
        end
        checks++;
        if (count_on(1, 16) != 8 || count_on(3, 10) != 8) begin
            errors++; $display("FAIL fdx_shift_on: total=%0d in_3_10=%0d, expected 8 and 8",
                               count_on(1, 16), count_on(3, 10));
        end
        checks++;
        if (first_rv(16) != 13) begin
            errors++; $display("FAIL fdx_rsp_latency: first rsp_valid at T+%0d, expected T+13", first_rv(16));
        end
        checks++;
        if (tr_rd[13] !== 32'h0000_005A) begin
            errors++; $display("FAIL fdx_rsp_data: got %h, expected 0000005a", tr_rd[13]);
        end
        checks++;
        for (int k = 1; k <= 13; k++) if (tr_cs[k] !== 1'b0) begin
            errors++; $display("FAIL fdx_cs_active: cs_n=%b at T+%0d, expected 0", tr_cs[k], k); break;
        end
        checks++;
        if ({tr_cs[14], tr_idle[14], tr_cs[15], tr_idle[15]} !== 4'b1011) begin
            errors++; $display("FAIL fdx_cs_release: cs/idle T+14=%b%b T+15=%b%b, expected 10 11",
                               tr_cs[14], tr_idle[14], tr_cs[15], tr_idle[15]);
        end
        checks++;
        if ({tr_wen[1], sread, dread} !== 3'b100 || shift_out_data !== 32'hA5 || wlen_ot !== 5'd7) begin
            errors++; $display("FAIL fdx_fields: wen/sr/dr=%b%b%b data=%h wlen=%0d, expected 100 a5 7",
                               tr_wen[1], sread, dread, shift_out_data, wlen_ot);
        end
    endtask

    task automatic test_dread();
        int bad;
        shift_in_data = 32'h1234_5678;
        send(32'h0000_00C3, 5'd7, 2'd2, 2'd1, 1'b0);
        trace(12);
        checks++;
        if (count_on(1, 12) != 4 || first_on(12) != 3) begin
            errors++; $display("FAIL dread_shift_on: count=%0d first=T+%0d, expected 4 at T+3",
                               count_on(1, 12), first_on(12));
        end
        bad = 0;
        for (int k = 1; k <= 11; k++) if (tr_dr[k] !== 1'b1 || tr_wen[k] !== 1'b0) bad++;
        checks++;
        if (bad != 0 || sread !== 1'b0) begin
            errors++; $display("FAIL dread_mode_bits: bad_cycles=%0d sread=%b, expected 0 and 0", bad, sread);
        end
        checks++;
        if (first_rv(12) != 9 || tr_rd[9] !== 32'h1234_5678 || csnum !== 2'd1) begin
            errors++; $display("FAIL dread_rsp: at T+%0d data=%h csnum=%0d, expected T+9 12345678 1",
                               first_rv(12), tr_rd[9], csnum);
        end
    endtask

    task automatic test_hold_same();
        shift_in_data = 32'h0000_0011;
        send(32'h0000_000F, 5'd3, 2'd0, 2'd2, 1'b1);
        trace(9);
        checks++;
        if (tr_rv[9] !== 1'b1 || tr_rd[9] !== 32'h11) begin
            errors++; $display("FAIL hold_same_rsp1: valid=%b data=%h, expected 1 00000011", tr_rv[9], tr_rd[9]);
        end
        checks++;
        if ({cs_n, idle, cmd_ready} !== 3'b001) begin
            errors++; $display("FAIL hold_same_between: cs_n/idle/ready=%b%b%b, expected 001", cs_n, idle, cmd_ready);
        end
        shift_in_data = 32'h0000_0022;
        send(32'h0000_00F0, 5'd3, 2'd0, 2'd2, 1'b0);
        trace(10);
        checks++;
        if (tr_load[1] !== 1'b1 || first_on(10) != 2 || count_on(1, 10) != 4) begin
            errors++; $display("FAIL hold_same_no_setup: load=%b first_on=T+%0d count=%0d, expected 1 T+2 4",
                               tr_load[1], first_on(10), count_on(1, 10));
        end
        checks++;
        for (int k = 1; k <= 8; k++) if (tr_cs[k] !== 1'b0) begin
            errors++; $display("FAIL hold_same_cs: cs_n=%b at T+%0d, expected 0", tr_cs[k], k); break;
        end
        checks++;
        if (first_rv(10) != 8 || tr_rd[8] !== 32'h22 || tr_cs[9] !== 1'b1 || tr_idle[10] !== 1'b1) begin
            errors++; $display("FAIL hold_same_end: rsp at T+%0d data=%h cs9=%b idle10=%b, expected T+8 22 1 1",
                               first_rv(10), tr_rd[8], tr_cs[9], tr_idle[10]);
        end
    endtask

    task automatic test_hold_switch();
        shift_in_data = 32'h0000_0033;
        send(32'h0000_0001, 5'd3, 2'd0, 2'd0, 1'b1);
        trace(9);
        checks++;
        if (cs_n !== 1'b0) begin
            errors++; $display("FAIL hold_switch_held: cs_n=%b, expected 0", cs_n);
        end
        shift_in_data = 32'h0000_0044;
        send(32'h0000_0002, 5'd3, 2'd0, 2'd1, 1'b0);
        trace(12);
        checks++;
        if ({tr_cs[1], tr_load[1], tr_cs[2], tr_load[2]} !== 4'b1001) begin
            errors++; $display("FAIL hold_switch_csoff: T+1 cs/load=%b%b T+2 cs/load=%b%b, expected 10 01",
                               tr_cs[1], tr_load[1], tr_cs[2], tr_load[2]);
        end
        checks++;
        if (first_on(12) != 4 || first_rv(12) != 10 || tr_rd[10] !== 32'h44 || csnum !== 2'd1) begin
            errors++; $display("FAIL hold_switch_xfer: on T+%0d rsp T+%0d data=%h csnum=%0d, expected T+4 T+10 44 1",
                               first_on(12), first_rv(12), tr_rd[10], csnum);
        end
    endtask

    task automatic set_cmd(input int i);
        cmd_data = 32'h0000_0100 + i; cmd_wlen = 5'd0; cmd_mode = 2'd0; cmd_csnum = 2'd3;
        cmd_hold = (i < 2);
    endtask

    task automatic test_stall();
        logic [31:0] exp_d [0:2];
        int idx, loads, nr;
        logic hs;
        exp_d[0] = 32'hAAAA_0001; exp_d[1] = 32'hBBBB_0002; exp_d[2] = 32'hCCCC_0003;
        rsp_ready = 1'b0; idx = 0; loads = 0; nr = 0;
        set_cmd(0); cmd_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (shift_out_load && loads < 3) begin shift_in_data = exp_d[loads]; loads++; end
            hs = cmd_valid && cmd_ready;
            step();
            if (hs) begin idx++; if (idx < 3) set_cmd(idx); else cmd_valid = 1'b0; end
        end
        checks++;
        if (loads != EXP_ACC || idx != EXP_ACC || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL stall_point: loads=%0d accepted=%0d ready=%b, expected %0d %0d 0",
                               loads, idx, cmd_ready, EXP_ACC, EXP_ACC);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_d[0] || cs_n !== 1'b0) begin
            errors++; $display("FAIL stall_hold_rsp: valid=%b data=%h cs_n=%b, expected 1 %h 0",
                               rsp_valid, rsp_data, cs_n, exp_d[0]);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 80 && nr < 3; c++) begin
            if (shift_out_load && loads < 3) begin shift_in_data = exp_d[loads]; loads++; end
            if (rsp_valid) begin
                checks++;
                if (rsp_data !== exp_d[nr]) begin
                    errors++; $display("FAIL stall_order: rsp %0d data=%h, expected %h", nr, rsp_data, exp_d[nr]);
                end
                nr++;
            end
            hs = cmd_valid && cmd_ready;
            step();
            if (hs) begin idx++; if (idx < 3) set_cmd(idx); else cmd_valid = 1'b0; end
        end
        checks++;
        if (nr != 3) begin
            errors++; $display("FAIL stall_drain: responses=%0d, expected 3", nr);
        end
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (idle !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL stall_final_idle: idle=%b rsp_valid=%b, expected 1 0", idle, rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        shift_in_data = 32'h0000_0077;
        send(32'h0000_0009, 5'd0, 2'd0, 2'd0, 1'b0);
        send(32'h0000_00A5, 5'd7, 2'd0, 2'd0, 1'b0);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pending: rsp_valid=%b, expected 1", rsp_valid);
        end
        for (int k = 1; k < 5; k++) step();
        checks++;
        if (shift_on !== 1'b1) begin
            errors++; $display("FAIL rstmid_in_shift: shift_on=%b at T+5, expected 1", shift_on);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({cs_n, shift_on, rsp_valid, idle, cmd_ready} !== 5'b10011) begin
            errors++; $display("FAIL rstmid_after: cs_n/on/rv/idle/ready=%b, expected 10011",
                               {cs_n, shift_on, rsp_valid, idle, cmd_ready});
        end
        checks++;
        if (shift_out_data !== 32'd0 || wlen_ot !== 5'd0 || write_en !== 1'b0) begin
            errors++; $display("FAIL rstmid_fields: data=%h wlen=%0d wen=%b, expected 0",
                               shift_out_data, wlen_ot, write_en);
        end
        rsp_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1; shift_in_data = '0;
        cmd_data = '0; cmd_wlen = '0; cmd_mode = '0; cmd_csnum = '0; cmd_hold = 1'b0;
        test_reset();
        test_fdx();
        test_dread();
        test_hold_same();
        test_hold_switch();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
